// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer that owns the HI/LO registers.
// Optional flush support is enabled by defining MDU_CANCEL_EN.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hilo_sel,
    input  logic        d_is_md,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hilo_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MC4 = 4'(MULT_CYCLES);
    localparam logic [3:0] DC4 = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;
    logic        cancel_i;

`ifdef MDU_CANCEL_EN
    assign cancel_i = cancel;
`else
    assign cancel_i = 1'b0;
`endif

    logic is_mul;
    logic is_div;
    logic is_mthi;
    logic is_mtlo;
    logic start_md;

    assign is_mul   = (op == 3'd1) || (op == 3'd2);
    assign is_div   = (op == 3'd3) || (op == 3'd4);
    assign is_mthi  = (op == 3'd5);
    assign is_mtlo  = (op == 3'd6);
    assign start_md = start & (is_mul | is_div);

    assign stall_req  = d_is_md & (busy | start_md);
    assign hilo_rdata = hilo_sel ? lo : hi;

    logic [63:0] rs_sx;
    logic [63:0] rt_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] dv;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] nxt_hi;
    logic [31:0] nxt_lo;

    assign rs_sx  = {{32{rs_data[31]}}, rs_data};
    assign rt_sx  = {{32{rt_data[31]}}, rt_data};
    assign prod_s = $signed(rs_sx) * $signed(rt_sx);
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    // A zero divisor never commits, and MIN/-1 is forced to divide by one
    // so the quotient wraps to MIN with a zero remainder.
    assign div_zero = (rt_data == 32'd0);
    assign div_ovf  = (rs_data == 32'h8000_0000)
                   && (rt_data == 32'hFFFF_FFFF)
                   && (op == 3'd3);
    assign dv  = (div_zero || div_ovf) ? 32'd1 : rt_data;
    assign q_s = $signed(rs_data) / $signed(dv);
    assign r_s = $signed(rs_data) % $signed(dv);
    assign q_u = rs_data / dv;
    assign r_u = rs_data % dv;

    // Result selection for the operation being started
    always_comb begin
        nxt_hi = 32'd0;
        nxt_lo = 32'd0;
        case (op)
            3'd1: {nxt_hi, nxt_lo} = prod_s;
            3'd2: {nxt_hi, nxt_lo} = prod_u;
            3'd3: begin
                nxt_hi = r_s;
                nxt_lo = q_s;
            end
            3'd4: begin
                nxt_hi = r_u;
                nxt_lo = q_u;
            end
            default: ;
        endcase
    end

    // Sequencer: latch result at start, commit HI/LO when cnt runs out
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            busy   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_wr <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !cancel_i) begin
                        unique case (1'b1)
                            is_mul, is_div: begin
                                res_hi <= nxt_hi;
                                res_lo <= nxt_lo;
                                res_wr <= !(is_div && div_zero);
                                cnt    <= is_mul ? MC4 : DC4;
                                busy   <= 1'b1;
                                state  <= RUN;
                            end
                            is_mthi: hi <= rs_data;
                            is_mtlo: lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cancel_i) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd1) begin
                        if (res_wr) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl
// against an arithmetic reference model of HI/LO.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        hilo_sel;
    logic        d_is_md;
`ifdef MDU_CANCEL_EN
    logic        cancel = 1'b0;
`endif
    logic        busy;
    logic        stall_req;
    logic [31:0] hilo_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .rs_data(rs),
        .rt_data(rt),
        .hilo_sel(hilo_sel),
        .d_is_md(d_is_md),
`ifdef MDU_CANCEL_EN
        .cancel(cancel),
`endif
        .busy(busy),
        .stall_req(stall_req),
        .hilo_rdata(hilo_rdata),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {commit, hi, lo} from plain 64-bit arithmetic
    function automatic logic [64:0] ref_op(input logic [2:0] o,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd1: begin
                v = sa * sb;
                return {1'b1, v};
            end
            3'd2: begin
                v = ua * ub;
                return {1'b1, v};
            end
            3'd3: begin
                if (b == 32'd0) return 65'd0;
                q = sa / sb;
                r = sa % sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return 65'd0;
                uq = ua / ub;
                ur = ua % ub;
                return {1'b1, ur[31:0], uq[31:0]};
            end
            default: return 65'd0;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0;
        rs = 32'd0; rt = 32'd0; hilo_sel = 1'b0; d_is_md = 1'b1;
        tick(); tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        tests++;
        if (hi !== 32'd0) begin
            fails++; $display("FAIL reset_hi: got %h want 0", hi);
        end
        tests++;
        if (lo !== 32'd0) begin
            fails++; $display("FAIL reset_lo: got %h want 0", lo);
        end
        tests++;
        if (stall_req !== 1'b0) begin
            fails++; $display("FAIL reset_stall: got %b want 0", stall_req);
        end
    endtask

    task automatic test_mult();
        d_is_md = 1'b1; start = 1'b1; op = 3'd1;
        rs = 32'hFFFF_FFFE; rt = 32'd3;
        #1;
        tests++;
        if (stall_req !== 1'b1) begin
            fails++; $display("FAIL mult_start_stall: got %b want 1", stall_req);
        end
        tick();
        start = 1'b0; op = 3'd0;
        #1;
        for (int i = 0; i < MC; i++) begin
            tests++;
            if ({busy, stall_req, hi, lo} !== {2'b11, m_hi, m_lo}) begin
                fails++;
                $display("FAIL mult_run[%0d]: got b=%b s=%b %h/%h want 1 1 %h/%h",
                         i, busy, stall_req, hi, lo, m_hi, m_lo);
            end
            tick();
        end
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFA;
        tests++;
        if ({busy, stall_req, hi, lo} !== {2'b00, m_hi, m_lo}) begin
            fails++;
            $display("FAIL mult_done: got b=%b s=%b %h/%h want 0 0 %h/%h",
                     busy, stall_req, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_div();
        logic [2:0]  to [3] = '{3'd4, 3'd3, 3'd3};
        logic [31:0] ta [3] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] tb [3] = '{32'd7, 32'd2, 32'hFFFF_FFFF};
        logic [31:0] th [3] = '{32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] tl [3] = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000};
        for (int k = 0; k < 3; k++) begin
            d_is_md = 1'b0; start = 1'b1; op = to[k];
            rs = ta[k]; rt = tb[k];
            tick();
            start = 1'b0; op = 3'd0;
            #1;
            for (int i = 0; i < DC; i++) begin
                tests++;
                if ({busy, hi, lo} !== {1'b1, m_hi, m_lo}) begin
                    fails++;
                    $display("FAIL div%0d_run[%0d]: got b=%b %h/%h want 1 %h/%h",
                             k, i, busy, hi, lo, m_hi, m_lo);
                end
                tick();
            end
            m_hi = th[k]; m_lo = tl[k];
            tests++;
            if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
                fails++;
                $display("FAIL div%0d_done: got b=%b %h/%h want 0 %h/%h",
                         k, busy, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_mtlo();
        d_is_md = 1'b1; start = 1'b1; op = 3'd6; rs = 32'h1234_5678;
        tick();
        start = 1'b0; op = 3'd0;
        m_lo = 32'h1234_5678;
        hilo_sel = 1'b1;
        #1;
        tests++;
        if ({busy, stall_req, lo} !== {2'b00, m_lo}) begin
            fails++;
            $display("FAIL mtlo: got b=%b s=%b lo=%h want 0 0 %h",
                     busy, stall_req, lo, m_lo);
        end
        tests++;
        if (hilo_rdata !== 32'h1234_5678) begin
            fails++; $display("FAIL mtlo_rdata: got %h want 12345678", hilo_rdata);
        end
        start = 1'b1; op = 3'd5; rs = 32'hCAFE_F00D;
        tick();
        start = 1'b0; op = 3'd0;
        m_hi = 32'hCAFE_F00D;
        hilo_sel = 1'b0;
        #1;
        tests++;
        if ({busy, hi, lo, hilo_rdata} !== {1'b0, m_hi, m_lo, m_hi}) begin
            fails++;
            $display("FAIL mthi: got b=%b %h/%h rd=%h want 0 %h/%h rd=%h",
                     busy, hi, lo, hilo_rdata, m_hi, m_lo, m_hi);
        end
    endtask

    task automatic test_back_to_back();
        d_is_md = 1'b1; start = 1'b1; op = 3'd2;
        rs = 32'h0001_0000; rt = 32'h0003_0000;
        tick();
        start = 1'b0; op = 3'd0;
        #1;
        for (int i = 0; i < MC; i++) begin
            tests++;
            if ({busy, stall_req, hi, lo} !== {2'b11, m_hi, m_lo}) begin
                fails++;
                $display("FAIL b2b_run[%0d]: got b=%b s=%b %h/%h want 1 1 %h/%h",
                         i, busy, stall_req, hi, lo, m_hi, m_lo);
            end
            start = (i == 1 || i == 2);
            op    = (i == 1) ? 3'd4 : 3'd5;
            rs    = 32'd9; rt = 32'd2;
            tick();
            start = 1'b0; op = 3'd0;
            #1;
        end
        m_hi = 32'd3; m_lo = 32'd0;
        tests++;
        if ({busy, stall_req, hi, lo} !== {2'b00, m_hi, m_lo}) begin
            fails++;
            $display("FAIL b2b_done: got b=%b s=%b %h/%h want 0 0 %h/%h",
                     busy, stall_req, hi, lo, m_hi, m_lo);
        end
        for (int i = 0; i < DC; i++) tick();
        tests++;
        if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
            fails++;
            $display("FAIL b2b_late: got b=%b %h/%h want 0 %h/%h",
                     busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_div_zero();
        start = 1'b1; op = 3'd5; rs = 32'hA;
        tick();
        op = 3'd6; rs = 32'hB;
        tick();
        m_hi = 32'hA; m_lo = 32'hB;
        op = 3'd3; rs = 32'd5; rt = 32'd0;
        tick();
        start = 1'b0; op = 3'd0;
        #1;
        for (int i = 0; i < DC; i++) begin
            tests++;
            if ({busy, hi, lo} !== {1'b1, m_hi, m_lo}) begin
                fails++;
                $display("FAIL divz_run[%0d]: got b=%b %h/%h want 1 %h/%h",
                         i, busy, hi, lo, m_hi, m_lo);
            end
            tick();
        end
        tests++;
        if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
            fails++;
            $display("FAIL divz_done: got b=%b %h/%h want 0 %h/%h",
                     busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        logic [64:0] r;
        logic        hs;
        int          sel, n, exp_n;
        for (int k = 0; k < 40; k++) begin
            o   = 3'($urandom_range(1, 6));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin
                a = 32'h8000_0000; b = 32'hFFFF_FFFF;
            end else if (sel == 2) b = 32'($urandom_range(1, 9));
            hs = 1'($urandom_range(0, 1));
            start = 1'b1; op = o; rs = a; rt = b; hilo_sel = hs;
            tick();
            start = 1'b0; op = 3'd0;
            #1;
            if (o >= 3'd5) begin
                if (o == 3'd5) m_hi = a;
                else m_lo = a;
                tests++;
                if (busy !== 1'b0) begin
                    fails++; $display("FAIL rnd%0d_busy: got %b want 0", k, busy);
                end
            end else begin
                r = ref_op(o, a, b);
                exp_n = (o <= 3'd2) ? MC : DC;
                n = 0;
                while (busy === 1'b1 && n < DC + 5) begin
                    n++;
                    tick();
                end
                tests++;
                if (n !== exp_n) begin
                    fails++;
                    $display("FAIL rnd%0d_cycles op=%0d: got %0d want %0d",
                             k, o, n, exp_n);
                end
                if (r[64]) {m_hi, m_lo} = r[63:0];
            end
            tests++;
            if ({hi, lo} !== {m_hi, m_lo}) begin
                fails++;
                $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h: got %h/%h want %h/%h",
                         k, o, a, b, hi, lo, m_hi, m_lo);
            end
            tests++;
            if (hilo_rdata !== (hs ? m_lo : m_hi)) begin
                fails++;
                $display("FAIL rnd%0d_rdata: got %h want %h",
                         k, hilo_rdata, hs ? m_lo : m_hi);
            end
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = 3'd6; rs = 32'h55;
        tick();
        op = 3'd3; rs = 32'd100; rt = 32'd3;
        tick();
        start = 1'b0; op = 3'd0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        #1;
        tests++;
        if ({busy, hi, lo} !== {1'b0, 64'd0}) begin
            fails++;
            $display("FAIL rstmid: got b=%b %h/%h want 0 0/0", busy, hi, lo);
        end
        for (int i = 0; i < DC + 3; i++) tick();
        tests++;
        if ({busy, hi, lo} !== {1'b0, 64'd0}) begin
            fails++;
            $display("FAIL rstmid_late: got b=%b %h/%h want 0 0/0", busy, hi, lo);
        end
    endtask

`ifdef MDU_CANCEL_EN
    task automatic test_cancel();
        start = 1'b1; op = 3'd5; rs = 32'h11;
        tick();
        op = 3'd6; rs = 32'h22;
        tick();
        m_hi = 32'h11; m_lo = 32'h22;
        op = 3'd3; rs = 32'd100; rt = 32'd3;
        tick();
        start = 1'b0; op = 3'd0;
        tick(); tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        #1;
        tests++;
        if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
            fails++;
            $display("FAIL cancel_run: got b=%b %h/%h want 0 %h/%h",
                     busy, hi, lo, m_hi, m_lo);
        end
        for (int i = 0; i < DC; i++) tick();
        tests++;
        if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
            fails++;
            $display("FAIL cancel_late: got b=%b %h/%h want 0 %h/%h",
                     busy, hi, lo, m_hi, m_lo);
        end
        cancel = 1'b1; start = 1'b1; op = 3'd5; rs = 32'h99;
        tick();
        op = 3'd1; rs = 32'd3; rt = 32'd4;
        tick();
        cancel = 1'b0; start = 1'b0; op = 3'd0;
        #1;
        tests++;
        if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
            fails++;
            $display("FAIL cancel_start: got b=%b %h/%h want 0 %h/%h",
                     busy, hi, lo, m_hi, m_lo);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mtlo();
        test_back_to_back();
        test_div_zero();
        test_random();
        test_reset_mid();
`ifdef MDU_CANCEL_EN
        test_cancel();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
